// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_stage                                                     |
// | Description : Instruction-fetch stage: PC register, ROM addressing, IF/ID  |
// |               register, stall/redirect handling, saturating stall counter. |
// |               Define IF_DELAY_SLOT_EN to keep the delay-slot instruction   |
// |               on redirect instead of flushing it.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_stage #(
  parameter int                 PC_W     = 8,
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               R,
  input  logic               LE,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ID_instruction,
  output logic [PC_W-1:0]    ID_pc_next,
  output logic               ID_valid,
  output logic [15:0]        stall_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [15:0] c_stall_max = 16'hFFFF;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_stall_inc;

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_id_instr;
  logic [PC_W-1:0]    r_id_pc_next;
  logic               r_id_valid;
  logic [15:0]        r_stall_count;

  logic [PC_W-1:0]    w_pc_plus4;
  logic [PC_W-1:0]    w_pc_d;
  logic [INSTR_W-1:0] w_id_instr_d;
  logic [PC_W-1:0]    w_id_pc_next_d;
  logic               w_id_valid_d;

  assign w_pc_plus4 = r_pc + PC_W'(4);

  // Stall-accounting FSM; the datapath below does not depend on it.
  always_comb begin
    w_state_next = r_state;
    w_stall_inc  = 1'b0;
    case (r_state)
      RUN: begin
        if (!LE) begin
          w_state_next = HOLD;
          w_stall_inc  = 1'b1;
        end
      end
      HOLD: begin
        if (LE) w_state_next = RUN;
        else    w_stall_inc  = 1'b1;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_pc_d         = r_pc;
    w_id_instr_d   = r_id_instr;
    w_id_pc_next_d = r_id_pc_next;
    w_id_valid_d   = r_id_valid;
    if (LE) begin
      if (branch_taken) begin
        w_pc_d = {branch_target[PC_W-1:2], 2'b00};
`ifdef IF_DELAY_SLOT_EN
        w_id_instr_d   = rom_data;
        w_id_pc_next_d = w_pc_plus4;
        w_id_valid_d   = 1'b1;
`else
        w_id_instr_d   = NOP_WORD;
        w_id_pc_next_d = '0;
        w_id_valid_d   = 1'b0;
`endif
      end else begin
        w_pc_d         = w_pc_plus4;
        w_id_instr_d   = rom_data;
        w_id_pc_next_d = w_pc_plus4;
        w_id_valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state       <= RUN;
      r_pc          <= '0;
      r_id_instr    <= NOP_WORD;
      r_id_pc_next  <= '0;
      r_id_valid    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_d;
      r_id_instr   <= w_id_instr_d;
      r_id_pc_next <= w_id_pc_next_d;
      r_id_valid   <= w_id_valid_d;
      if (w_stall_inc && (r_stall_count != c_stall_max))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign rom_addr       = r_pc;
  assign ID_instruction = r_id_instr;
  assign ID_pc_next     = r_id_pc_next;
  assign ID_valid       = r_id_valid;
  assign stall_count    = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_stage                                                  |
// | Description : Directed self-checking bench for if_stage.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_if_stage;

  logic        clk = 1'b0;
  logic        R;
  logic        LE;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] ID_instruction;
  logic [7:0]  ID_pc_next;
  logic        ID_valid;
  logic [15:0] stall_count;

  int n_total  = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  // Each ROM word encodes its own byte address so mis-fetches are visible.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {16'hC0DE, 8'h00, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  if_stage #(
    .PC_W    (8),
    .INSTR_W (32),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .R             (R),
    .LE            (LE),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .ID_instruction(ID_instruction),
    .ID_pc_next    (ID_pc_next),
    .ID_valid      (ID_valid),
    .stall_count   (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    R = 1'b0; LE = 1'b1; branch_taken = 1'b0; branch_target = 8'h00;

    // Reset held for three edges
    repeat (3) step();
    check("rst_rom_addr", {24'h0, rom_addr}, 32'h0);
    check("rst_instr",    ID_instruction,    32'h0);
    check("rst_pc_next",  {24'h0, ID_pc_next}, 32'h0);
    check("rst_valid",    {31'h0, ID_valid}, 32'h0);
    check("rst_stall",    {16'h0, stall_count}, 32'h0);

    R = 1'b1;
    step();
    check("f0_instr",   ID_instruction, rom_word(8'h00));
    check("f0_pc_next", {24'h0, ID_pc_next}, 32'h4);
    check("f0_valid",   {31'h0, ID_valid}, 32'h1);
    check("f0_addr",    {24'h0, rom_addr}, 32'h4);
    step();
    check("f1_instr",   ID_instruction, rom_word(8'h04));
    check("f1_pc_next", {24'h0, ID_pc_next}, 32'h8);

    // Stall three cycles at PC=8
    LE = 1'b0;
    repeat (3) step();
    check("stl_addr",    {24'h0, rom_addr}, 32'h8);
    check("stl_instr",   ID_instruction, rom_word(8'h04));
    check("stl_pc_next", {24'h0, ID_pc_next}, 32'h8);
    check("stl_count",   {16'h0, stall_count}, 32'd3);
    LE = 1'b1;
    step();
    check("res_instr", ID_instruction, rom_word(8'h08));
    check("res_addr",  {24'h0, rom_addr}, 32'hC);
    check("res_count", {16'h0, stall_count}, 32'd3);
    step();
    check("pc10_addr", {24'h0, rom_addr}, 32'h10);

    // Taken branch at PC=0x10 to 0x40
    branch_taken = 1'b1; branch_target = 8'h40;
    step();
    check("br_addr", {24'h0, rom_addr}, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    check("br_instr",   ID_instruction, rom_word(8'h10));
    check("br_valid",   {31'h0, ID_valid}, 32'h1);
    check("br_pc_next", {24'h0, ID_pc_next}, 32'h14);
`else
    check("br_instr",   ID_instruction, 32'h0);
    check("br_valid",   {31'h0, ID_valid}, 32'h0);
    check("br_pc_next", {24'h0, ID_pc_next}, 32'h0);
`endif
    branch_taken = 1'b0;
    step();
    check("tgt_instr",   ID_instruction, rom_word(8'h40));
    check("tgt_valid",   {31'h0, ID_valid}, 32'h1);
    check("tgt_pc_next", {24'h0, ID_pc_next}, 32'h44);

    // Misaligned target is forced to a word boundary
    branch_taken = 1'b1; branch_target = 8'h43;
    step();
    check("align_addr", {24'h0, rom_addr}, 32'h40);

    // Wrap from 0xF8 through 0xFC to 0x00
    branch_target = 8'hF8;
    step();
    check("wrap_f8", {24'h0, rom_addr}, 32'hF8);
    branch_taken = 1'b0;
    step();
    check("wrap_fc",    {24'h0, rom_addr}, 32'hFC);
    check("wrap_i_f8",  ID_instruction, rom_word(8'hF8));
    step();
    check("wrap_00",    {24'h0, rom_addr}, 32'h00);
    check("wrap_i_fc",  ID_instruction, rom_word(8'hFC));
    check("wrap_pcn",   {24'h0, ID_pc_next}, 32'h00);

    // Stall beats a simultaneous branch; the branch is dropped
    LE = 1'b0; branch_taken = 1'b1; branch_target = 8'h80;
    step();
    check("cf_addr",  {24'h0, rom_addr}, 32'h00);
    check("cf_instr", ID_instruction, rom_word(8'hFC));
    check("cf_count", {16'h0, stall_count}, 32'd4);
    LE = 1'b1; branch_taken = 1'b0;
    step();
    check("cf_after_addr",  {24'h0, rom_addr}, 32'h04);
    check("cf_after_instr", ID_instruction, rom_word(8'h00));

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    R = 1'b0;
    #1;
    check("ar_addr",  {24'h0, rom_addr}, 32'h0);
    check("ar_instr", ID_instruction, 32'h0);
    check("ar_pcn",   {24'h0, ID_pc_next}, 32'h0);
    check("ar_valid", {31'h0, ID_valid}, 32'h0);
    check("ar_count", {16'h0, stall_count}, 32'h0);
    step();
    R = 1'b1;
    step();
    check("ar_rel_instr", ID_instruction, rom_word(8'h00));
    check("ar_rel_valid", {31'h0, ID_valid}, 32'h1);
    check("ar_rel_addr",  {24'h0, rom_addr}, 32'h4);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline: holds the program counter, addresses the instruction ROM, and loads the IF/ID register that feeds the Control Unit and decode logic. It applies hazard stalls, redirects on taken branches (flush or delay-slot), and keeps a saturating stall-cycle counter for performance debug. It replaces the loose PC / PC_adder / IF_ID trio with a single stage whose behaviour is fully defined.

## Interface
Parameters:
- PC_W, 8, program-counter / ROM address width (byte address)
- INSTR_W, 32, instruction width
- NOP_WORD, 32'h0000_0000, value loaded into IF/ID on flush

Ports:
- clk  in  1  rising-edge clock
- R  in  1  reset, asynchronous, active-low
- LE  in  1  load enable from hazard unit; 0 = stall (hold PC and IF/ID)
- branch_taken  in  1  taken branch/BL resolved in ID this cycle
- branch_target  in  PC_W  branch destination (byte address)
- rom_addr  out  PC_W  address to combinational ROM (= current PC)
- rom_data  in  INSTR_W  instruction word returned by ROM, same cycle
- ID_instruction  out  INSTR_W  IF/ID instruction register
- ID_pc_next  out  PC_W  IF/ID copy of PC+4 of that instruction (BL link value)
- ID_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- stall_count  out  16  saturating count of stalled cycles since reset

## Operation
- Reset (R=0, immediate, clock-independent): PC=0, rom_addr=0, ID_instruction=NOP_WORD, ID_pc_next=0, ID_valid=0, stall_count=0, state=RUN.
- State machine, 2 states: RUN, HOLD. RUN→HOLD when LE=0; HOLD→RUN when LE=1; state only drives stall accounting, datapath is governed by the priority below.
- Per rising edge, priority highest first:
  1. LE=0 (stall): PC, ID_instruction, ID_pc_next, ID_valid unchanged; stall_count += 1 unless at 16'hFFFF. branch_taken ignored.
  2. LE=1 and branch_taken=1 (redirect): PC <= {branch_target[PC_W-1:2], 2'b00}; IF/ID per Configuration.
  3. LE=1 normal: PC <= PC+4; ID_instruction <= rom_data; ID_pc_next <= PC+4; ID_valid <= 1.
- PC arithmetic: modulo 2^PC_W; PC+4 from 8'hFC wraps to 8'h00, no error flag. PC[1:0] always 00; branch_target[1:0] discarded.
- rom_addr is combinational from the PC register (no extra register).
- stall_count saturates at 16'hFFFF, cleared only by reset.

## Timing
- Fetch latency: instruction at PC appears on ID_instruction one clk edge after PC is presented.
- Branch penalty: branch_taken in cycle N → target address on rom_addr in N+1 → target instruction in ID at N+2.
- Stall: LE=0 during N freezes all IF/ID outputs through edge N+1; fetch resumes with the same PC.
- Reset asserted mid-stream clears all state asynchronously; first edge after R release with LE=1 loads instruction at address 0, ID_valid=1.
- Simultaneous LE=0 and branch_taken=1: stall wins, branch dropped; hazard unit must re-assert branch_taken once LE=1.

## Configuration
- IF_DELAY_SLOT_EN defined: on redirect the instruction already fetched (rom_data at old PC, the delay slot) is loaded into IF/ID with ID_valid=1, ID_pc_next=old PC+4; it executes.
- IF_DELAY_SLOT_EN undefined: on redirect IF/ID <= NOP_WORD, ID_pc_next=0, ID_valid=0 (one-bubble flush).

## Test plan
- Reset: R=0 for 3 cycles with ROM preloaded → all outputs at reset values; release, LE=1 → ID_instruction = Mem[0] after first edge, Mem[4] after second, ID_pc_next = 4 then 8.
- Stall: LE=0 for 3 cycles at PC=8 → rom_addr stays 8, ID outputs frozen, stall_count = 3; LE=1 → fetch continues from 8.
- Branch (no macro): branch_taken=1, target=8'h40 at PC=0x10 → next edge ID_valid=0, ID_instruction=0, PC=0x40; following edge ID_instruction=Mem[0x40].
- Branch (IF_DELAY_SLOT_EN): same stimulus → ID_instruction=Mem[0x10], ID_valid=1, then Mem[0x40].
- Wrap and alignment: run from PC=0xF8 → 0xFC → 0x00; branch_target=8'h43 → PC=0x40.
- Conflict and async reset: LE=0 with branch_taken=1 → PC unchanged, branch dropped; assert R=0 mid-cycle → outputs clear before next clk edge.
